// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file writeback constants
package regfile_pkg;
  localparam int RF_AW   = 4;
  localparam int RF_DW   = 32;
  localparam int RF_NREQ = 4;

  // Fixed requester slots on the writeback port.
  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_LINK  = 2'd2,
    WB_SPARE = 2'd3
  } wb_src_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter owning its rotating pointer
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = RF_NREQ
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   idx;
  logic          found;

  // Wrap is a compare-and-subtract so non-power-of-2 NREQ never leaves 0..NREQ-1.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (en && Clr && !found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
        ptr_d              = (idx[PW-1:0] == PW'(NREQ-1)) ? '0 : idx[PW-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - shares the register-file write port among writeback sources
module regfile_wport_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ    = RF_NREQ,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               hold,
  output logic [NREQ-1:0]    ack,
  output logic [AW-1:0]      dec_D,
  output logic               dec_L,
  output logic [DW-1:0]      wr_data
);
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          any_grant;
  logic [AW-1:0] dec_d_q, dec_d_d;
  logic          dec_l_q, dec_l_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .Clk   (Clk),
    .Clr   (Clr),
    .en    (!hold),
    .req   (req),
    .grant (ack)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // A write to r0 is still acknowledged; only its enable is suppressed.
  always_comb begin
    any_grant = |ack;
    dec_l_d   = any_grant && !(R0_ZERO && (sel_addr == '0));
    dec_d_d   = any_grant ? sel_addr : dec_d_q;
    wr_data_d = any_grant ? sel_data : wr_data_q;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      dec_d_q   <= '0;
      dec_l_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      dec_d_q   <= dec_d_d;
      dec_l_q   <= dec_l_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign dec_D   = dec_d_q;
  assign dec_L   = dec_l_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;
  import regfile_pkg::*;
  localparam int NREQ = RF_NREQ;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic               Clk = 1'b0;
  logic               Clr;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               hold;
  logic [NREQ-1:0]    ack1, ack0;
  logic [AW-1:0]      dec_d1, dec_d0;
  logic               dec_l1, dec_l0;
  logic [DW-1:0]      wr_data1, wr_data0;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wport_arbiter #(.R0_ZERO(1'b1)) dut1 (
    .Clk(Clk), .Clr(Clr), .req(req), .req_addr(req_addr), .req_data(req_data),
    .hold(hold), .ack(ack1), .dec_D(dec_d1), .dec_L(dec_l1), .wr_data(wr_data1)
  );

  regfile_wport_arbiter #(.R0_ZERO(1'b0)) dut0 (
    .Clk(Clk), .Clr(Clr), .req(req), .req_addr(req_addr), .req_data(req_data),
    .hold(hold), .ack(ack0), .dec_D(dec_d0), .dec_L(dec_l0), .wr_data(wr_data0)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input logic h, input int p);
    if (h) return -1;
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Reference: rotating priority, one-cycle issue, r0 writes dropped for R0_ZERO=1.
  int            m_ptr = 0;
  logic [AW-1:0] m_d   = '0;
  logic [DW-1:0] m_w   = '0;
  logic          m_l1  = 1'b0;
  logic          m_l0  = 1'b0;
  logic [DW-1:0] m_rf [16];
  logic [DW-1:0] d_rf [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
  end

  always @(posedge Clk or negedge Clr) begin
    int w;
    if (!Clr) begin
      m_ptr = 0; m_d = '0; m_w = '0; m_l1 = 1'b0; m_l0 = 1'b0;
    end else begin
      w = winner(req, hold, m_ptr);
      if (w >= 0) begin
        m_d   = req_addr[w*AW +: AW];
        m_w   = req_data[w*DW +: DW];
        m_l0  = 1'b1;
        m_l1  = (m_d != 0);
        if (m_l1) m_rf[m_d] = m_w;
        m_ptr = (w + 1) % NREQ;
      end else begin
        m_l0 = 1'b0;
        m_l1 = 1'b0;
      end
    end
  end

  always @(negedge Clk) begin
    int w;
    logic [NREQ-1:0] ea;
    w  = Clr ? winner(req, hold, m_ptr) : -1;
    ea = (w >= 0) ? (NREQ'(1) << w) : '0;
    chk("m_ack_r0z1", ack1, ea);
    chk("m_ack_r0z0", ack0, ea);
    chk("m_decd_r0z1", dec_d1, m_d);
    chk("m_decd_r0z0", dec_d0, m_d);
    chk("m_wdata_r0z1", wr_data1, m_w);
    chk("m_wdata_r0z0", wr_data0, m_w);
    chk("m_decl_r0z1", dec_l1, m_l1);
    chk("m_decl_r0z0", dec_l0, m_l0);
    if (dec_l1) d_rf[dec_d1] = wr_data1;
  end

  task automatic to_neg();
    @(negedge Clk); #1;
  endtask

  task automatic to_pos();
    @(posedge Clk); #1;
  endtask

  initial begin
    int cnt;
    Clr = 1'b0; req = '0; hold = 1'b0; req_addr = '0; req_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ack", ack1, 0);
    chk("reset_decl", dec_l1, 0);
    chk("reset_decd", dec_d1, 0);
    chk("reset_wdata", wr_data1, 0);
    Clr = 1'b1;

    for (int i = 0; i < NREQ; i++) set_slot(i, AW'(8 + i), 32'h1000 + i);
    req = 4'b1111;
    to_pos();
    to_pos();
    #2 Clr = 1'b0;
    #1;
    chk("midrst_ack", ack1, 0);
    chk("midrst_decl", dec_l1, 0);
    chk("midrst_decd", dec_d1, 0);
    chk("midrst_wdata", wr_data1, 0);
    to_pos();
    Clr = 1'b1;

    for (int k = 0; k < 5; k++) begin
      to_neg();
      if (k < 4) chk("fair_ack", ack1, 1 << k);
      if (k > 0) begin
        chk("fair_decl", dec_l1, 1);
        chk("fair_decd", dec_d1, 8 + k - 1);
      end
      to_pos();
      if (k < 4) req[k] = 1'b0;
    end

    set_slot(int'(WB_LOAD), 4'h5, 32'hDEAD_BEEF);
    req = 4'b0010;
    to_neg(); chk("single_ack", ack1, 4'b0010);
    to_pos(); req = '0;
    to_neg();
    chk("single_decd", dec_d1, 4'h5);
    chk("single_decl", dec_l1, 1);
    chk("single_wdata", wr_data1, 32'hDEAD_BEEF);
    to_pos();
    to_neg(); chk("single_decl_off", dec_l1, 0);

    to_pos();
    set_slot(int'(WB_ALU), 4'h7, 32'hA5A5_0007);
    req = 4'b0001;
    to_neg(); chk("hold_pre_ack", ack1, 4'b0001);
    to_pos();
    hold = 1'b1; req = 4'b0100;
    set_slot(int'(WB_LINK), 4'h9, 32'h0C0C_0009);
    to_neg();
    chk("hold_ack1", ack1, 0);
    chk("hold_staged_decl", dec_l1, 1);
    chk("hold_staged_decd", dec_d1, 4'h7);
    to_pos();
    to_neg(); chk("hold_ack2", ack1, 0); chk("hold_decl2", dec_l1, 0);
    to_pos();
    to_neg(); chk("hold_ack3", ack1, 0);
    to_pos(); hold = 1'b0;
    to_neg(); chk("hold_rel_ack", ack1, 4'b0100);
    to_pos(); req = '0;
    to_neg(); chk("hold_rel_decl", dec_l1, 1); chk("hold_rel_decd", dec_d1, 4'h9);

    to_pos();
    set_slot(int'(WB_ALU), 4'h0, 32'h55);
    req = 4'b0001;
    to_neg(); chk("r0_ack", ack1, 4'b0001);
    to_pos(); req = '0;
    to_neg();
    chk("r0_decl_z1", dec_l1, 0);
    chk("r0_decl_z0", dec_l0, 1);
    chk("r0_decd_z0", dec_d0, 0);
    chk("r0_wdata_z0", wr_data0, 32'h55);

    to_pos();
    set_slot(int'(WB_SPARE), 4'h4, 32'h44);
    req = 4'b1000;
    to_neg();
    to_pos();
    set_slot(int'(WB_ALU), 4'h3, 32'd1);
    set_slot(int'(WB_LINK), 4'h3, 32'd2);
    req = 4'b0101;
    to_neg(); chk("same_ack0", ack1, 4'b0001);
    to_pos(); req = 4'b0100;
    to_neg(); chk("same_ack2", ack1, 4'b0100); chk("same_first_data", wr_data1, 1); chk("same_first_addr", dec_d1, 3);
    to_pos(); req = '0;
    to_neg(); chk("same_second_data", wr_data1, 2); chk("same_second_decl", dec_l1, 1);
    chk("same_final_dut", d_rf[3], 2);
    chk("same_final_model", m_rf[3], 2);

    to_pos();
    set_slot(int'(WB_LOAD), 4'h6, 32'h66);
    req = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      to_neg();
      if (ack1 == 4'b0010) cnt++;
      to_pos();
    end
    req = '0;
    chk("cont_grants", cnt, 4);

    hold = 1'b1;
    set_slot(int'(WB_SPARE), 4'hE, 32'hEE);
    req = 4'b1000;
    to_pos();
    req = '0; hold = 1'b0;
    to_neg(); chk("withdraw_ack", ack1, 0);
    to_pos();
    to_neg(); chk("withdraw_decl", dec_l1, 0); chk("withdraw_rf", d_rf[14], 0);

    to_pos();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
